differentiation: RTL and testbench

Inverse of the signal-path accumulator: recovers a per-interval rate from a stream of signed 32-bit integrated samples by taking the difference between consecutive samples. It then scales the difference by a power-of-two right shift and saturates it to a 16-bit signed output. It sits downstream of the integration stage and upstream of the 16-bit sample consumers. It has valid/ready flow control on both sides, a two-state priming FSM, and a synchronous re-arm input.

---
 rtl/differentiation.sv | 115 +++++++++++
 tb/tb_differentiation.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/differentiation.sv
// First-difference stage: turns a stream of signed integrated samples into a
// scaled, saturated per-interval rate with valid/ready handshaking on both sides.
module differentiation #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             primed
);

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_e;

  localparam int UP_W = IN_W - OUT_W + 2;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    prev_q, prev_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;

  logic               accept;
  logic               produce;
  logic signed [IN_W:0] diff;
  logic signed [IN_W:0] scaled;
  logic [UP_W-1:0]    upper;
  logic               in_range;
  logic [OUT_W-1:0]   sat_data;
  logic               sat_flag;

  // A full output register may still take a new sample in the cycle it drains.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign produce  = accept && (state_q == PRIMED) && !clr;

  // One extra bit keeps the difference exact for any pair of full-scale inputs.
  assign diff   = $signed({in_data[IN_W-1], in_data}) - $signed({prev_q[IN_W-1], prev_q});
  assign scaled = diff >>> SHIFT;

  // The value fits in OUT_W bits only if every bit above the output sign bit
  // matches it; otherwise the sign of the wide value picks the clip rail.
  assign upper    = scaled[IN_W:OUT_W-1];
  assign in_range = (upper == '0) || (upper == '1);

  always_comb begin
    sat_data = scaled[OUT_W-1:0];
    sat_flag = 1'b0;
    if (!in_range) begin
      sat_flag = 1'b1;
      sat_data = scaled[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through this block can infer a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clr) begin
      state_d = EMPTY;
      prev_d  = '0;
    end

    if (accept) begin
      prev_d  = in_data;
      state_d = PRIMED;
    end

    if (produce) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_data;
      out_sat_d   = sat_flag;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign primed    = (state_q == PRIMED);

endmodule

// File: tb/tb_differentiation.sv
// Directed bench for differentiation: one unshifted instance and one SHIFT=3
// instance share the same stimulus; each scenario task checks its own results.
module tb_differentiation;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic [31:0]        in_data;
  logic               out_ready;

  logic               in_ready0, out_valid0, out_sat0, primed0;
  logic signed [15:0] out_data0;
  logic               in_ready3, out_valid3, out_sat3, primed3;
  logic signed [15:0] out_data3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  differentiation #(.IN_W(32), .OUT_W(16), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_sat(out_sat0), .primed(primed0)
  );

  differentiation #(.IN_W(32), .OUT_W(16), .SHIFT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_sat(out_sat3), .primed(primed3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  // Drive one valid sample with out_ready high and let one edge pass.
  task automatic push(input logic [31:0] d);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd123;
    tick();
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || primed0 !== 1'b0 || out_data0 !== 16'sd0 || out_sat0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b primed=%b data=%0d sat=%b want 0 0 0 0",
               out_valid0, primed0, out_data0, out_sat0);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if (primed0 !== 1'b0) begin errors++; $display("FAIL reset_ignores_input: primed=%b want 0", primed0); end
  endtask

  task automatic test_priming();
    apply_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 32'd1000;
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || primed0 !== 1'b1) begin
      errors++; $display("FAIL prime_first: valid=%b primed=%b want 0 1", out_valid0, primed0);
    end
    in_data = 32'd1500;
    tick();
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd500 || out_sat0 !== 1'b0) begin
      errors++; $display("FAIL prime_out1: valid=%b data=%0d sat=%b want 1 500 0", out_valid0, out_data0, out_sat0);
    end
    in_data = 32'd1250;
    tick();
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== -16'sd250 || out_sat0 !== 1'b0) begin
      errors++; $display("FAIL prime_out2: valid=%b data=%0d sat=%b want 1 -250 0", out_valid0, out_data0, out_sat0);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL prime_drain: valid=%b want 0", out_valid0); end
  endtask

  task automatic test_saturation();
    apply_reset();
    push(32'd0);
    push(32'd40000);
    checks++;
    if (out_data0 !== 16'sd32767 || out_sat0 !== 1'b1) begin
      errors++; $display("FAIL sat_pos: data=%0d sat=%b want 32767 1", out_data0, out_sat0);
    end
    push(-32'sd40000);
    checks++;
    if (out_data0 !== -16'sd32768 || out_sat0 !== 1'b1) begin
      errors++; $display("FAIL sat_neg: data=%0d sat=%b want -32768 1", out_data0, out_sat0);
    end
    push(-32'sd7233);   // difference exactly +32767
    checks++;
    if (out_data0 !== 16'sd32767 || out_sat0 !== 1'b0) begin
      errors++; $display("FAIL edge_max: data=%0d sat=%b want 32767 0", out_data0, out_sat0);
    end
    push(-32'sd40001);  // difference exactly -32768
    checks++;
    if (out_data0 !== -16'sd32768 || out_sat0 !== 1'b0) begin
      errors++; $display("FAIL edge_min: data=%0d sat=%b want -32768 0", out_data0, out_sat0);
    end
    push(-32'sd72770);  // difference -32769
    checks++;
    if (out_data0 !== -16'sd32768 || out_sat0 !== 1'b1) begin
      errors++; $display("FAIL edge_min_minus1: data=%0d sat=%b want -32768 1", out_data0, out_sat0);
    end
  endtask

  task automatic test_shift();
    apply_reset();
    push(32'd0);
    push(-32'sd9);
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== -16'sd2 || out_sat3 !== 1'b0) begin
      errors++; $display("FAIL shift_neg: valid=%b data=%0d sat=%b want 1 -2 0", out_valid3, out_data3, out_sat3);
    end
    push(32'd7);
    checks++;
    if (out_data3 !== 16'sd2 || out_sat3 !== 1'b0) begin
      errors++; $display("FAIL shift_pos: data=%0d sat=%b want 2 0", out_data3, out_sat3);
    end
  endtask

  task automatic test_extremes();
    apply_reset();
    push(32'h8000_0000);
    push(32'h7FFF_FFFF);
    checks++;
    if (out_data0 !== 16'sd32767 || out_sat0 !== 1'b1) begin
      errors++; $display("FAIL extreme_up: data=%0d sat=%b want 32767 1", out_data0, out_sat0);
    end
    push(32'h8000_0000);
    checks++;
    if (out_data0 !== -16'sd32768 || out_sat0 !== 1'b1) begin
      errors++; $display("FAIL extreme_down: data=%0d sat=%b want -32768 1", out_data0, out_sat0);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'd10;
    tick();
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_ready_before: got %b want 1", in_ready0); end
    in_data = 32'd20;
    tick();
    in_data = 32'd30;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 16'sd10 || in_ready0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b data=%0d in_ready=%b want 1 10 0", i, out_valid0, out_data0, in_ready0);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready0); end
    tick();   // first output handed off, 30 accepted
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd10) begin
      errors++; $display("FAIL bp_out2: valid=%b data=%0d want 1 10", out_valid0, out_data0);
    end
    in_data = 32'd40;
    tick();
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd10) begin
      errors++; $display("FAIL bp_out3: valid=%b data=%0d want 1 10", out_valid0, out_data0);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_drain: valid=%b want 0", out_valid0); end
  endtask

  task automatic test_clr();
    apply_reset();
    push(32'd100);
    clr = 1'b1;
    push(32'd500);
    clr = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || primed0 !== 1'b1) begin
      errors++; $display("FAIL clr_accept: valid=%b primed=%b want 0 1", out_valid0, primed0);
    end
    push(32'd700);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd200) begin
      errors++; $display("FAIL clr_next: valid=%b data=%0d want 1 200", out_valid0, out_data0);
    end
    out_ready = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd200 || primed0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_keeps_output: valid=%b data=%0d primed=%b want 1 200 0", out_valid0, out_data0, primed0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("FAIL clr_drain: valid=%b want 0", out_valid0); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'd5;
    tick();
    in_data = 32'd8;
    tick();
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd3) begin
      errors++; $display("FAIL mid_pending: valid=%b data=%0d want 1 3", out_valid0, out_data0);
    end
    rst_n = 1'b0; out_ready = 1'b1; in_data = 32'd100;
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || primed0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: valid=%b primed=%b want 0 0", out_valid0, primed0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || primed0 !== 1'b1) begin
      errors++; $display("FAIL mid_reprime: valid=%b primed=%b want 0 1", out_valid0, primed0);
    end
    in_data = 32'd150;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'sd50) begin
      errors++; $display("FAIL mid_after: valid=%b data=%0d want 1 50", out_valid0, out_data0);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_priming();
    test_saturation();
    test_shift();
    test_extremes();
    test_back_pressure();
    test_clr();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
